// File: rtl/uart_status_reporter.sv
// Watches CHANNELS status values and emits one ASCII line per change ("LD: 0x12AB\r\n").
// Lines leave one byte at a time on a valid/ready interface feeding the UART transmitter.
module uart_status_reporter #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    CHANNELS    = 2,
  parameter int                    VALUE_WIDTH = 16,
  parameter logic [16*CHANNELS-1:0] TAGS       = {"7S", "LD"},
  parameter bit                    APPEND_CRLF = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ena,
  input  logic [CHANNELS*VALUE_WIDTH-1:0] ch_value,
  input  logic [CHANNELS-1:0]             force_report,
  input  logic                            tx_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic                            busy,
  output logic [CHANNELS-1:0]             pending
);

  localparam int HEX_DIGITS = (VALUE_WIDTH + 3) / 4;
  localparam int HEX_W      = 4 * HEX_DIGITS;
  localparam int MSG_LEN    = 6 + HEX_DIGITS + (APPEND_CRLF ? 2 : 0);
  localparam int IDX_W      = $clog2(MSG_LEN);
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_e;

  state_e                          state_q, state_d;
  logic [CH_W-1:0]                 sel_q, sel_d;
  logic [CH_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [HEX_W-1:0]                send_val_q, send_val_d;
  logic [IDX_W-1:0]                byte_idx_q, byte_idx_d;
  logic [CHANNELS*VALUE_WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0]             pending_q, pending_d;
  logic [DATA_WIDTH-1:0]           out_data_q, out_data_d;
  logic                            out_valid_q, out_valid_d;

  logic [CHANNELS-1:0] pend_set, pend_clr;
  logic [CH_W-1:0]     pick;
  logic                found;
  int                  cand;
  logic [HEX_W-1:0]    sel_shadow;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte idx of the line for channel ch carrying value val.
  function automatic logic [7:0] msg_byte(input int idx, input logic [CH_W-1:0] ch,
                                          input logic [HEX_W-1:0] val);
    logic [15:0] tag;
    logic [3:0]  nib;
    logic [7:0]  b;
    tag = 16'h0000;
    for (int i = 0; i < CHANNELS; i++)
      if (ch == CH_W'(i)) tag = TAGS[16*i +: 16];
    nib = 4'h0;
    b   = 8'h0A;
    if (idx == 0)      b = tag[15:8];
    else if (idx == 1) b = tag[7:0];
    else if (idx == 2) b = 8'h3A;
    else if (idx == 3) b = 8'h20;
    else if (idx == 4) b = 8'h30;
    else if (idx == 5) b = 8'h78;
    else if (idx < 6 + HEX_DIGITS) begin
      nib = 4'(val >> (4 * (5 + HEX_DIGITS - idx)));
      b   = hex_ascii(nib);
    end else if (idx == 6 + HEX_DIGITS) b = 8'h0D;
    return b;
  endfunction

  // NOTE: every variable gets a default before any branch, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    pend_set   = force_report;
    shadow_d   = shadow_q;
    sel_shadow = '0;
    pick       = '0;
    found      = 1'b0;
    cand       = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_value[VALUE_WIDTH*i +: VALUE_WIDTH] != shadow_q[VALUE_WIDTH*i +: VALUE_WIDTH]) begin
        shadow_d[VALUE_WIDTH*i +: VALUE_WIDTH] = ch_value[VALUE_WIDTH*i +: VALUE_WIDTH];
        pend_set[i] = 1'b1;
      end
      if (sel_q == CH_W'(i)) sel_shadow = HEX_W'(shadow_q[VALUE_WIDTH*i +: VALUE_WIDTH]);
    end
    // First pending channel at or after rr_ptr, wrapping.
    for (int k = 0; k < CHANNELS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!found && pending_q[cand]) begin
        found = 1'b1;
        pick  = CH_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    send_val_d  = send_val_q;
    byte_idx_d  = byte_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pend_clr    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_LOAD;
          sel_d   = pick;
        end
      end
      ST_LOAD: begin
        send_val_d = sel_shadow;
        byte_idx_d = '0;
        rr_ptr_d   = (int'(sel_q) == CHANNELS - 1) ? '0 : sel_q + CH_W'(1);
        for (int i = 0; i < CHANNELS; i++)
          if (sel_q == CH_W'(i)) pend_clr[i] = 1'b1;
        out_data_d  = DATA_WIDTH'(msg_byte(0, sel_q, sel_shadow));
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (int'(byte_idx_q) == MSG_LEN - 1) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            out_data_d = DATA_WIDTH'(msg_byte(int'(byte_idx_q) + 1, sel_q, send_val_q));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A set in the same cycle as the LOAD clear wins, so that change gets its own line.
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // NOTE: state registers use non-blocking assignments so every register sees the
  // same pre-edge values; the reset is synchronous and only acts on a clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      send_val_q  <= '0;
      byte_idx_q  <= '0;
      shadow_q    <= '0;
      pending_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      send_val_q  <= send_val_d;
      byte_idx_q  <= byte_idx_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign pending   = pending_q;

endmodule

// File: tb/tb_uart_status_reporter.sv
// Bench for uart_status_reporter: message-level reference model compared every cycle,
// directed scenarios with literal byte streams, and a narrow 1-channel instance.
module tb_uart_status_reporter;

  typedef logic [7:0] bq_t[$];
  localparam logic [15:0] CRLF = 16'h0D0A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic        rst_n = 1'b0, ena = 1'b1, tx_ready = 1'b1;
  logic [31:0] ch_value = '0;
  logic [1:0]  force_report = '0;
  logic [7:0]  out_data;
  logic        out_valid, busy;
  logic [1:0]  pending;

  uart_status_reporter dut (
    .clk(clk), .reset_n(rst_n), .ena(ena), .ch_value(ch_value),
    .force_report(force_report), .tx_ready(tx_ready), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .pending(pending)
  );

  // Narrow instance: one 10-bit channel, no CR/LF.
  logic       rst2_n = 1'b0, ena2 = 1'b1, rdy2 = 1'b1;
  logic [9:0] val2 = '0;
  logic [0:0] force2 = '0;
  logic [7:0] data2;
  logic       valid2, busy2;
  logic [0:0] pend2;

  uart_status_reporter #(
    .CHANNELS(1), .VALUE_WIDTH(10), .TAGS(16'h4C44), .APPEND_CRLF(1'b0)
  ) dut2 (
    .clk(clk), .reset_n(rst2_n), .ena(ena2), .ch_value(val2),
    .force_report(force2), .tx_ready(rdy2), .out_data(data2),
    .out_valid(valid2), .busy(busy2), .pending(pend2)
  );

  int n_cmp = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Transferred-byte logs (sole writers).
  bq_t tx1_q, tx2_q;
  always @(posedge clk) begin
    if (rst_n && ena && out_valid && tx_ready) tx1_q.push_back(out_data);
    if (rst2_n && ena2 && valid2 && rdy2) tx2_q.push_back(data2);
  end

  function automatic logic [511:0] pack_from(input bq_t q, input int start);
    logic [511:0] r = '0;
    for (int i = start; i < q.size(); i++) r = {r[503:0], q[i]};
    return r;
  endfunction

  // Whole message for a channel, built from the text format.
  function automatic bq_t build_msg(input int ch, input logic [15:0] v);
    string hex = "0123456789ABCDEF";
    string head;
    bq_t   q;
    head = (ch == 0) ? "LD: 0x" : "7S: 0x";
    for (int i = 0; i < head.len(); i++) q.push_back(head[i]);
    for (int d = 3; d >= 0; d--) q.push_back(hex[int'((v >> (4 * d)) & 16'hF)]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  // Reference model: phase 0 idle, 1 loading, 2 sending m_msg[m_idx].
  logic [15:0] m_shadow[2];
  logic [1:0]  m_pend;
  int          m_phase, m_sel, m_rr, m_idx;
  bq_t         m_msg;

  task automatic model_step();
    logic [1:0] new_pend;
    bit         found;
    if (!rst_n) begin
      m_shadow[0] = '0; m_shadow[1] = '0;
      m_pend = '0; m_phase = 0; m_rr = 0; m_sel = 0; m_idx = 0;
      m_msg.delete();
      return;
    end
    if (!ena) return;
    new_pend = m_pend;
    found    = 1'b0;
    case (m_phase)
      0: begin
        for (int k = 0; k < 2; k++) begin
          int c;
          c = (m_rr + k) % 2;
          if (!found && m_pend[c]) begin found = 1'b1; m_sel = c; end
        end
        if (found) m_phase = 1;
      end
      1: begin
        m_msg = build_msg(m_sel, m_shadow[m_sel]);
        new_pend[m_sel] = 1'b0;
        m_rr    = (m_sel + 1) % 2;
        m_idx   = 0;
        m_phase = 2;
      end
      default: begin
        if (tx_ready) begin
          m_idx++;
          if (m_idx == m_msg.size()) m_phase = 0;
        end
      end
    endcase
    for (int i = 0; i < 2; i++) begin
      if (ch_value[16*i +: 16] != m_shadow[i]) begin
        m_shadow[i] = ch_value[16*i +: 16];
        new_pend[i] = 1'b1;
      end
      if (force_report[i]) new_pend[i] = 1'b1;
    end
    m_pend = new_pend;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_valid", 512'(out_valid), 512'(m_phase == 2));
      check("model_busy", 512'(busy), 512'(m_phase != 0));
      check("model_pending", 512'(pending), 512'(m_pend));
      if (m_phase == 2) check("model_data", 512'(out_data), 512'(m_msg[m_idx]));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; tx_ready = 1'b1; force_report = '0; ch_value = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    do begin tick(); n++; end while ((busy || (|pending)) && n < max_cycles);
    check("idle_reached", 512'({busy, pending}), 512'(0));
  endtask

  int base, n, k;
  logic [3:0] pat;

  initial begin
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_out_data", 512'(out_data), 512'(0));
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_pending", 512'(pending), 512'(0));
    rst_n = 1'b1;

    check("pin_msg_ld", pack_from(build_msg(0, 16'h12AB), 0), 512'({"LD: 0x12AB", CRLF}));
    check("pin_msg_7s", pack_from(build_msg(1, 16'h0ABC), 0), 512'({"7S: 0x0ABC", CRLF}));

    // Single change, latency and byte stream.
    do_reset();
    base = tx1_q.size();
    ch_value[15:0] = 16'h12AB;
    tick();
    check("lat_e0_valid", 512'(out_valid), 512'(0));
    check("lat_e0_pending", 512'(pending), 512'(2'b01));
    tick();
    check("lat_e1_valid", 512'(out_valid), 512'(0));
    check("lat_e1_busy", 512'(busy), 512'(1));
    tick();
    check("lat_e2_valid", 512'(out_valid), 512'(1));
    check("lat_e2_data", 512'(out_data), 512'(8'h4C));
    check("load_clears_pending", 512'(pending), 512'(0));
    wait_idle(40);
    check("msg_12ab", pack_from(tx1_q, base), 512'({"LD: 0x12AB", CRLF}));
    check("msg_12ab_len", 512'(tx1_q.size() - base), 512'(12));

    // Simultaneous changes, round-robin, twice.
    do_reset();
    base = tx1_q.size();
    ch_value = {16'h0ABC, 16'h0001};
    wait_idle(80);
    check("dual_1", pack_from(tx1_q, base), 512'({"LD: 0x0001", CRLF, "7S: 0x0ABC", CRLF}));
    base = tx1_q.size();
    ch_value = {16'h0BBB, 16'h0002};
    wait_idle(80);
    check("dual_2", pack_from(tx1_q, base), 512'({"LD: 0x0002", CRLF, "7S: 0x0BBB", CRLF}));

    // Backpressure with tx_ready cycling 1,0,0,1.
    do_reset();
    base = tx1_q.size();
    ch_value[15:0] = 16'h5A5A;
    pat = 4'b1001;
    n = 0; k = 0;
    do begin
      tick();
      tx_ready = pat[3 - (k % 4)];
      k++; n++;
    end while ((busy || (|pending)) && n < 120);
    tx_ready = 1'b1;
    check("bp_idle", 512'({busy, pending}), 512'(0));
    check("bp_count", 512'(tx1_q.size() - base), 512'(12));
    check("bp_msg", pack_from(tx1_q, base), 512'({"LD: 0x5A5A", CRLF}));

    // Latest value wins while another channel is sending.
    do_reset();
    base = tx1_q.size();
    ch_value[31:16] = 16'h0055;
    repeat (5) tick();
    ch_value[15:0] = 16'h1111; tick();
    ch_value[15:0] = 16'h2222; tick();
    ch_value[15:0] = 16'h3333;
    wait_idle(80);
    check("latest_wins", pack_from(tx1_q, base), 512'({"7S: 0x0055", CRLF, "LD: 0x3333", CRLF}));

    // Forced reports, including one coinciding with LOAD.
    do_reset();
    base = tx1_q.size();
    force_report = 2'b10; tick(); force_report = 2'b00;
    wait_idle(40);
    check("force_msg", pack_from(tx1_q, base), 512'({"7S: 0x0000", CRLF}));
    base = tx1_q.size();
    force_report = 2'b10; tick();
    force_report = 2'b00; tick();
    force_report = 2'b10; tick();
    force_report = 2'b00;
    check("set_wins_pending", 512'(pending), 512'(2'b10));
    wait_idle(80);
    check("force_in_load", pack_from(tx1_q, base), 512'({"7S: 0x0000", CRLF, "7S: 0x0000", CRLF}));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n        = ($urandom_range(0, 599) != 0);
      ena          = ($urandom_range(0, 9) != 0);
      tx_ready     = ($urandom_range(0, 9) < 7);
      force_report = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      if ($urandom_range(0, 7) == 0) ch_value[15:0] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ch_value[31:16] = 16'($urandom);
    end
    tick();
    rst_n = 1'b1; ena = 1'b1; tx_ready = 1'b1; force_report = '0;
    wait_idle(200);

    // Narrow instance: 10-bit value, no CR/LF, then reset mid-message.
    rst2_n = 1'b1;
    base = tx2_q.size();
    val2 = 10'h3FF;
    n = 0;
    do begin tick(); n++; end while ((busy2 || tx2_q.size() == base) && n < 40);
    check("w10_msg", pack_from(tx2_q, base), 512'("LD: 0x3FF"));
    check("w10_len", 512'(tx2_q.size() - base), 512'(9));
    base = tx2_q.size();
    val2 = 10'h155;
    n = 0;
    do begin tick(); n++; end while (!valid2 && n < 10);
    check("w10_start", 512'(valid2), 512'(1));
    repeat (4) tick();
    check("w10_byte4", 512'(data2), 512'(8'h30));
    rst2_n = 1'b0; rdy2 = 1'b0; val2 = '0;
    tick();
    check("abort_valid", 512'(valid2), 512'(0));
    check("abort_pending", 512'(pend2), 512'(0));
    check("abort_busy", 512'(busy2), 512'(0));
    check("abort_data", 512'(data2), 512'(0));
    rst2_n = 1'b1; rdy2 = 1'b1;
    repeat (15) tick();
    check("abort_no_resume", 512'(tx2_q.size() - base), 512'(4));
    check("abort_partial", pack_from(tx2_q, base), 512'("LD: "));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_status_reporter.md
# uart_status_reporter

Parametrised multi-channel status-to-ASCII message generator feeding the UART transmitter.
- Watches CHANNELS input values of VALUE_WIDTH bits each and emits one ASCII line per change, e.g. "LD: 0x12AB\r\n".
- Messages go out one byte at a time over a valid/ready handshake.
- Round-robin arbitration between channels, per-channel forced reports, MSB-first hex digits and optional CR/LF termination.
- Sits between the board I/O mirror logic (LEDs, 7-segment elements, switches) and the UART TX byte interface.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width of out_data; only 8 is supported.
- CHANNELS, 2, number of monitored values; 1 to 8.
- VALUE_WIDTH, 16, bits per channel value; 1 to 32. HEX_DIGITS = ceil(VALUE_WIDTH/4); the value is zero-extended to 4*HEX_DIGITS bits.
- TAGS, {"7S","LD"}, packed 16*CHANNELS bits of two ASCII chars per channel; channel i uses TAGS[16i+15:16i], with the high byte sent first.
- APPEND_CRLF, 1, when 1 append 0x0D 0x0A to every message.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- ena  in  1  global enable; when 0 all state, including outputs, holds.
- ch_value  in  CHANNELS*VALUE_WIDTH  channel i = ch_value[VALUE_WIDTH*i +: VALUE_WIDTH].
- force_report  in  CHANNELS  1-cycle pulse per channel; requests a message even with no change.
- tx_ready  in  1  UART TX can accept a byte this cycle.
- out_data  out  DATA_WIDTH  current message byte.
- out_valid  out  1  out_data is valid; a byte is transferred on a cycle where out_valid and tx_ready are both 1.
- busy  out  1  FSM not in IDLE.
- pending  out  CHANNELS  per-channel report-pending flags.

## Operation
Message format, MSG_LEN = 6 + HEX_DIGITS + 2*APPEND_CRLF bytes:
- tag char 1, tag char 2, ':' 0x3A, ' ' 0x20, '0' 0x30, 'x' 0x78.
- Hex digits, most-significant nibble first, uppercase: 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
- Optional 0x0D 0x0A.

Change detection and pending flags:
- Each channel has a shadow register, reset to 0.
- On each enabled cycle, if ch_value_i != shadow_i, then shadow_i <= ch_value_i and pending_i <= 1.
- force_report_i also sets pending_i.
- While pending, shadow keeps tracking the input, so the latest value wins and intermediate values are dropped.

FSM, 3 states:
- IDLE: if any pending bit is set, go to LOAD. Select the first pending channel at or after rr_ptr (wrapping). Latch sel.
- LOAD: copy shadow_sel into send_val, clear pending_sel, set byte_idx = 0, set rr_ptr = sel+1 mod CHANNELS. Go to SEND.
- SEND: out_valid = 1, out_data = byte[byte_idx] derived from send_val and TAGS. On a transfer, increment byte_idx; on the transfer of byte MSG_LEN-1, go to IDLE.

Arbitration and value capture:
- A new change on the channel being sent sets pending again and produces a follow-up message.
- send_val is frozen for the whole message.

Boundary cases:
- Simultaneous pending-clear in LOAD and a new change or force on the same channel: set wins, pending stays 1.
- Simultaneous changes on several channels: all become pending and are served round-robin, one message each.
- CHANNELS=1: rr_ptr is constant 0.
- Reset in any state aborts the message; no partial-message resume.

## Timing
- Reset values: out_data 0, out_valid 0, busy 0, pending 0, shadows 0, rr_ptr 0, state IDLE.
- Latency: input change sampled at edge E0 sets pending at E0. IDLE to LOAD at E1, LOAD to SEND at E2. out_valid is high from E2, so byte 0 is valid 2 cycles after E0.
- out_data and out_valid are registered.
- With tx_ready held 1, one byte transfers per cycle and a message occupies MSG_LEN cycles in SEND.
- Each message costs 2 extra cycles (IDLE, LOAD) before the next message starts.
- While out_valid=1 and tx_ready=0, out_data and out_valid hold stable; out_valid never drops mid-message.
- ena=0: no transfer is counted even if tx_ready=1, and all registers hold. The TX side must gate with ena as well.
- Reset asserted mid-SEND: out_valid=0 after that edge.

## Test plan
- Default params, ch0 0x0000 to 0x12AB, tx_ready=1: out_valid rises 2 cycles after the change and emits 4C 44 3A 20 30 78 31 32 41 42 0D 0A back-to-back. pending[0] clears in LOAD and busy returns to 0.
- ch0 to 0x0001 and ch1 to 0x0ABC on the same cycle: two messages, LD first then 7S ("7S: 0x0ABC\r\n"). A later dual change is served LD then 7S again because rr_ptr wraps.
- tx_ready toggling 1,0,0,1 during SEND: each byte is held stable while tx_ready=0; no byte is lost or duplicated; total transfers = 12.
- ch0 changes to 0x1111, 0x2222, 0x3333 while ch1's message is sending: exactly one LD message with 0x3333 follows.
- force_report[1] with ch1 unchanged at 0: message "7S: 0x0000\r\n". Force coinciding with the LOAD of channel 1: a second message follows.
- VALUE_WIDTH=10, APPEND_CRLF=0, value 0x3FF: 9-byte message ending 33 46 46. Reset pulsed at byte 4 of SEND: out_valid=0 next cycle, pending=0, and no bytes follow.
